// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file with a reset clear sweep, optional
// write-through bypass, optional hard-wired zero register and a pending-write scoreboard.
module reg_file_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ar1,
    input  logic [ADDR_W-1:0] ar2,
    input  logic [ADDR_W-1:0] aw,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] dr1,
    output logic [DATA_W-1:0] dr2,
    output logic              busy1,
    output logic              busy2,
    output logic              ready
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                run, clr_last, wr_en, rsv_ok, z1, z2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        clr_last  = clr_ptr_q == '1;
        state_d   = (state_q == CLEAR && clr_last) ? RUN : state_q;
        clr_ptr_d = (state_q == CLEAR && !clr_last) ? clr_ptr_q + ADDR_W'(1) : clr_ptr_q;
    end

    always_comb begin
        run    = state_q == RUN;
        ready  = run;
        z1     = ZERO_REG && ar1 == '0;
        z2     = ZERO_REG && ar2 == '0;
        wr_en  = run && we && !(ZERO_REG && aw == '0);
        rsv_ok = run && rsv_en && !(ZERO_REG && rsv_addr == '0);
    end

    // A reservation in the same cycle as a completing write wins: it is a newer producer.
    always_comb begin
        busy_d = busy_q;
        if (run && we) busy_d[aw] = 1'b0;
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && !run) mem_q[clr_ptr_q] <= '0;
        else if (!rst && wr_en) mem_q[aw] <= data_in;
    end

    always_comb begin
        dr1   = (!run || z1) ? '0 : (BYPASS && wr_en && aw == ar1) ? data_in : mem_q[ar1];
        dr2   = (!run || z2) ? '0 : (BYPASS && wr_en && aw == ar2) ? data_in : mem_q[ar2];
        busy1 = run && !z1 && busy_q[ar1];
        busy2 = run && !z2 && busy_q[ar2];
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: table vectors plus randomized traffic against a behavioural model,
// driving a bypass instance and a non-bypass instance with the same stimulus.
module tb_reg_file_2r1w;
    logic        clk = 1'b0;
    logic        rst, we, rsv_en;
    logic [4:0]  ar1, ar2, aw, rsv_addr;
    logic [31:0] data_in;
    logic [31:0] b_dr1, b_dr2, n_dr1, n_dr2;
    logic        b_busy1, b_busy2, n_busy1, n_busy2, b_ready, n_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .ar1(ar1), .ar2(ar2), .aw(aw), .data_in(data_in), .we(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .dr1(b_dr1), .dr2(b_dr2),
        .busy1(b_busy1), .busy2(b_busy2), .ready(b_ready));

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst), .ar1(ar1), .ar2(ar2), .aw(aw), .data_in(data_in), .we(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .dr1(n_dr1), .dr2(n_dr2),
        .busy1(n_busy1), .busy2(n_busy2), .ready(n_ready));

    // Reference: reset zeroes the whole file at once and the file is unavailable for 32 cycles.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_clr = 0;
    bit          m_valid = 0;

    logic [31:0] s_dr1b, s_dr1n, s_dr2b;
    logic        s_busy1, s_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (m_clr > 0 || a == 0) return 32'h0;
        if (byp && we && aw == a) return data_in;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return m_clr == 0 && a != 0 && m_busy[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_valid = 1;
            m_clr = 32;
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'h0;
                m_busy[i] = 0;
            end
        end else if (m_clr > 0) begin
            m_clr--;
        end else begin
            if (we && aw != 0) m_mem[aw] = data_in;
            if (we) m_busy[aw] = 0;
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [4:0] a_w, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2, input logic rs, input logic [4:0] ra);
        rst = r; we = w; aw = a_w; data_in = d; ar1 = a1; ar2 = a2; rsv_en = rs; rsv_addr = ra;
        @(negedge clk);
        s_dr1b = b_dr1; s_dr1n = n_dr1; s_dr2b = b_dr2; s_busy1 = b_busy1; s_ready = b_ready;
        if (m_valid) begin
            check("ready_b", {31'b0, b_ready}, {31'b0, m_clr == 0});
            check("ready_n", {31'b0, n_ready}, {31'b0, m_clr == 0});
            check("dr1_b", b_dr1, exp_rd(ar1, 1));
            check("dr2_b", b_dr2, exp_rd(ar2, 1));
            check("dr1_n", n_dr1, exp_rd(ar1, 0));
            check("dr2_n", n_dr2, exp_rd(ar2, 0));
            check("busy1_b", {31'b0, b_busy1}, {31'b0, exp_busy(ar1)});
            check("busy2_b", {31'b0, b_busy2}, {31'b0, exp_busy(ar2)});
            check("busy1_n", {31'b0, n_busy1}, {31'b0, exp_busy(ar1)});
            check("busy2_n", {31'b0, n_busy2}, {31'b0, exp_busy(ar2)});
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cyc(0, 0, 5'd0, 32'h0, a1, a2, 0, 5'd0);
    endtask

    task automatic count_clear(input string name);
        int low = 0;
        for (int i = 0; i < 40; i++) begin
            idle(5'd0, 5'd0);
            if (!s_ready) low++;
        end
        check(name, low, 32);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  aw;
        logic [31:0] d;
        logic [4:0]  ar1, ar2;
        logic        rsv;
        logic [4:0]  ra;
        logic [31:0] e_dr1b, e_dr1n, e_dr2;
        logic        e_busy1;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1, 5'd5,  32'hDEADBEEF, 5'd0, 5'd0,  0, 5'd0, 32'h0,        32'h0,        32'h0,        0};
        tbl[1]  = '{1, 5'd31, 32'h12345678, 5'd5, 5'd0,  0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0};
        tbl[2]  = '{0, 5'd0,  32'h0,        5'd5, 5'd31, 0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 0};
        tbl[3]  = '{1, 5'd7,  32'hCAFEF00D, 5'd7, 5'd31, 0, 5'd0, 32'hCAFEF00D, 32'h0,        32'h12345678, 0};
        tbl[4]  = '{0, 5'd0,  32'h0,        5'd7, 5'd31, 0, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h12345678, 0};
        tbl[5]  = '{1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd31, 0, 5'd0, 32'h0,        32'h0,        32'h12345678, 0};
        tbl[6]  = '{0, 5'd0,  32'h0,        5'd0, 5'd31, 1, 5'd0, 32'h0,        32'h0,        32'h12345678, 0};
        tbl[7]  = '{0, 5'd0,  32'h0,        5'd0, 5'd31, 0, 5'd0, 32'h0,        32'h0,        32'h12345678, 0};
        tbl[8]  = '{0, 5'd0,  32'h0,        5'd9, 5'd31, 1, 5'd9, 32'h0,        32'h0,        32'h12345678, 0};
        tbl[9]  = '{1, 5'd9,  32'h11111111, 5'd9, 5'd31, 0, 5'd0, 32'h11111111, 32'h0,        32'h12345678, 1};
        tbl[10] = '{0, 5'd0,  32'h0,        5'd9, 5'd31, 0, 5'd0, 32'h11111111, 32'h11111111, 32'h12345678, 0};
        tbl[11] = '{1, 5'd9,  32'h22222222, 5'd9, 5'd31, 1, 5'd9, 32'h22222222, 32'h11111111, 32'h12345678, 0};
        tbl[12] = '{0, 5'd0,  32'h0,        5'd9, 5'd31, 0, 5'd0, 32'h22222222, 32'h22222222, 32'h12345678, 1};

        cyc(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);
        count_clear("first_clear_len");

        // Fill with garbage, then a one-cycle reset must sweep everything back to zero.
        for (int i = 0; i < 32; i++) cyc(0, 1, 5'(i), $urandom, 5'(i), 5'(31 - i), 1, 5'(i));
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
        cyc(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);
        count_clear("garbage_clear_len");
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(i));
            check("swept_zero", s_dr1b, 32'h0);
            check("swept_notbusy", {31'b0, s_busy1}, 32'h0);
        end

        for (int i = 0; i < 13; i++) begin
            cyc(0, tbl[i].we, tbl[i].aw, tbl[i].d, tbl[i].ar1, tbl[i].ar2, tbl[i].rsv, tbl[i].ra);
            check($sformatf("vec%0d_dr1_byp", i), s_dr1b, tbl[i].e_dr1b);
            check($sformatf("vec%0d_dr1_nobyp", i), s_dr1n, tbl[i].e_dr1n);
            check($sformatf("vec%0d_dr2", i), s_dr2b, tbl[i].e_dr2);
            check($sformatf("vec%0d_busy1", i), {31'b0, s_busy1}, {31'b0, tbl[i].e_busy1});
        end

        // Reset during RUN with busy bits set, then again ten cycles into the sweep.
        cyc(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd3);
        cyc(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd4);
        idle(5'd3, 5'd4);
        check("busy_before_rst", {31'b0, s_busy1}, 32'h1);
        cyc(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd6, 1, 5'd6);
        cyc(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 5'(10 + i), 32'h5A5A5A5A, 5'd5, 5'd6, 1, 5'(10 + i));
        begin
            int low = 10;
            for (int i = 0; i < 30; i++) begin
                idle(5'd0, 5'd0);
                if (!s_ready) low++;
            end
            check("restart_clear_len", low, 32);
        end
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(i));
            check("post_rst_zero", s_dr1b, 32'h0);
            check("post_rst_notbusy", {31'b0, s_busy1}, 32'h0);
        end

        for (int i = 0; i < 400; i++) begin
            logic [4:0] w_a, a1, a2;
            w_a = 5'($urandom_range(0, 7));
            a1  = ($urandom_range(0, 2) == 0) ? w_a : 5'($urandom_range(0, 7));
            a2  = ($urandom_range(0, 2) == 0) ? w_a : 5'($urandom);
            cyc(0, 1'($urandom), w_a, $urandom, a1, a2, 1'($urandom), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
